// File: rtl/tensor_core_pkg.sv
// Shared definitions for the tensor cores: run-state encoding, flattened matrix
// layout and the output formatting (wrap or clamp) applied to accumulator results.
package tensor_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Callers widen their accumulator to this width before formatting.
  localparam int FMT_W = 64;

  // Bit offset of element (i, j); element (0, 0) sits in the most significant slot.
  function automatic int elem_lsb(input int i, input int j, input int n, input int w);
    return ((n - 1 - i) * n + (n - 1 - j)) * w;
  endfunction

  function automatic logic signed [FMT_W-1:0] fmt_elem(
    input logic signed [FMT_W-1:0] acc,
    input int                      w,
    input logic                    is_signed,
    input logic                    saturate
  );
    logic signed [FMT_W-1:0] one;
    logic signed [FMT_W-1:0] hi;
    logic signed [FMT_W-1:0] lo;
    one = 1;
    if (!saturate) return acc;
    if (is_signed) begin
      hi = (one <<< (w - 1)) - one;
      lo = -(one <<< (w - 1));
    end else begin
      hi = (one <<< w) - one;
      lo = '0;
    end
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/param_tensor_core_if.sv
// Handshake and matrix bus between the register file (master) and the tensor core (slave).
interface param_tensor_core_if #(
  parameter int N = 4,
  parameter int W = 8
) ();

  logic             start;
  logic             accumulate_mode;
  logic             signed_mode;
  logic [N*N*W-1:0] tensor_core_input1;
  logic [N*N*W-1:0] tensor_core_input2;
  logic [N*N*W-1:0] tensor_core_output;
  logic             busy;
  logic             is_done_with_calculation;

  modport master (
    output start, accumulate_mode, signed_mode, tensor_core_input1, tensor_core_input2,
    input  tensor_core_output, busy, is_done_with_calculation
  );

  modport slave (
    input  start, accumulate_mode, signed_mode, tensor_core_input1, tensor_core_input2,
    output tensor_core_output, busy, is_done_with_calculation
  );

endinterface

// File: rtl/tensor_mac_unit.sv
// Combinational multiply-accumulate step: W x W -> 2W product, extended to ACC_W
// according to signed_mode_i, then added to the running sum.
module tensor_mac_unit #(
  parameter int W     = 8,
  parameter int ACC_W = 2 * W + 2
) (
  input  logic             signed_mode_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [ACC_W-1:0] addend_i,
  output logic [ACC_W-1:0] sum_o
);

  logic        [2*W-1:0]   prod_u;
  logic signed [2*W-1:0]   prod_s;
  logic        [ACC_W-1:0] prod_ext;

  assign prod_u   = a_i * b_i;
  assign prod_s   = $signed(a_i) * $signed(b_i);
  assign prod_ext = signed_mode_i ? {{(ACC_W - 2 * W){prod_s[2*W-1]}}, prod_s}
                                  : {{(ACC_W - 2 * W){1'b0}}, prod_u};
  assign sum_o    = addend_i + prod_ext;

endmodule

// File: rtl/param_tensor_core.sv
// Sequential NxN matrix-multiply engine, one MAC per clock, k innermost then col then row.
// Result elements are written as soon as their dot product completes.
module param_tensor_core #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int ACC_W    = 2 * W + $clog2(N),
  parameter int SATURATE = 0
) (
  input  logic              clock_in,
  input  logic              reset_in,
  param_tensor_core_if.slave bus
);

  import tensor_core_pkg::*;

  localparam int                 CNT_W = $clog2(N);
  localparam int                 MAT_W = N * N * W;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(N - 1);

  state_e                  state_q, state_d;
  logic [MAT_W-1:0]        a_q, a_d;
  logic [MAT_W-1:0]        b_q, b_d;
  logic [MAT_W-1:0]        out_q, out_d;
  logic                    acc_mode_q, acc_mode_d;
  logic                    sgn_q, sgn_d;
  logic [CNT_W-1:0]        row_q, row_d;
  logic [CNT_W-1:0]        col_q, col_d;
  logic [CNT_W-1:0]        k_q, k_d;
  logic [ACC_W-1:0]        acc_q, acc_d;

  int                      lsb_a, lsb_b, lsb_o;
  logic [W-1:0]            a_elem, b_elem, cur_elem, res_elem;
  logic [ACC_W-1:0]        init_val, addend, acc_next;
  logic signed [FMT_W-1:0] acc_wide;

  // Operand fetch and the starting value of each dot product.
  always_comb begin
    lsb_a    = elem_lsb(int'(row_q), int'(k_q), N, W);
    lsb_b    = elem_lsb(int'(k_q), int'(col_q), N, W);
    lsb_o    = elem_lsb(int'(row_q), int'(col_q), N, W);
    a_elem   = a_q[lsb_a +: W];
    b_elem   = b_q[lsb_b +: W];
    cur_elem = out_q[lsb_o +: W];
    if (!acc_mode_q)
      init_val = '0;
    else if (sgn_q)
      init_val = {{(ACC_W - W){cur_elem[W-1]}}, cur_elem};
    else
      init_val = {{(ACC_W - W){1'b0}}, cur_elem};
    addend = (k_q == '0) ? init_val : acc_q;
  end

  tensor_mac_unit #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .signed_mode_i (sgn_q),
    .a_i           (a_elem),
    .b_i           (b_elem),
    .addend_i      (addend),
    .sum_o         (acc_next)
  );

  always_comb begin
    acc_wide = sgn_q ? {{(FMT_W - ACC_W){acc_next[ACC_W-1]}}, acc_next}
                     : {{(FMT_W - ACC_W){1'b0}}, acc_next};
    res_elem = W'(fmt_elem(acc_wide, W, sgn_q, SATURATE != 0));
  end

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through this block can infer a latch.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    out_d      = out_q;
    acc_mode_d = acc_mode_q;
    sgn_d      = sgn_q;
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    acc_d      = acc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d        = bus.tensor_core_input1;
          b_d        = bus.tensor_core_input2;
          acc_mode_d = bus.accumulate_mode;
          sgn_d      = bus.signed_mode;
          row_d      = '0;
          col_d      = '0;
          k_d        = '0;
          acc_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d = acc_next;
        if (k_q == LAST) begin
          out_d[lsb_o +: W] = res_elem;
          k_d = '0;
          if (col_q == LAST) begin
            col_d = '0;
            if (row_q == LAST) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + CNT_W'(1);
            end
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of block order.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      out_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  // NOTE: operand and mode registers carry no reset; they are always loaded on the accepting edge before use.
  always_ff @(posedge clock_in) begin
    a_q        <= a_d;
    b_q        <= b_d;
    acc_mode_q <= acc_mode_d;
    sgn_q      <= sgn_d;
  end

  assign bus.tensor_core_output       = out_q;
  assign bus.busy                     = (state_q == RUN);
  assign bus.is_done_with_calculation = (state_q == DONE);

endmodule

// File: tb/tb_param_tensor_core.sv
// Drives a wrapping and a saturating core with identical stimulus and compares both
// against a plain-arithmetic matrix model.
module tb_param_tensor_core;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int MAT_W   = N * N * W;
  localparam int RUN_CYC = N * N * N;

  typedef int mat_t [N][N];

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  mat_t m_wrap, m_sat;

  always #5 clk = ~clk;

  param_tensor_core_if #(.N(N), .W(W)) bus0 ();
  param_tensor_core_if #(.N(N), .W(W)) bus1 ();

  assign bus1.start              = bus0.start;
  assign bus1.accumulate_mode    = bus0.accumulate_mode;
  assign bus1.signed_mode        = bus0.signed_mode;
  assign bus1.tensor_core_input1 = bus0.tensor_core_input1;
  assign bus1.tensor_core_input2 = bus0.tensor_core_input2;

  param_tensor_core #(.N(N), .W(W), .SATURATE(0)) dut_wrap (
    .clock_in (clk),
    .reset_in (rst),
    .bus      (bus0)
  );

  param_tensor_core #(.N(N), .W(W), .SATURATE(1)) dut_sat (
    .clock_in (clk),
    .reset_in (rst),
    .bus      (bus1)
  );

  task automatic check(input string tag, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] pack(input mat_t m);
    logic [MAT_W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        v[((N - 1 - i) * N + (N - 1 - j)) * W +: W] = W'(m[i][j]);
    return v;
  endfunction

  function automatic longint sval(input int x, input bit sgn);
    if (sgn && x >= (1 << (W - 1))) return longint'(x) - (longint'(1) << W);
    return longint'(x);
  endfunction

  function automatic int fmt_ref(input longint s, input bit sgn, input bit sat);
    longint lo, hi, v;
    v = s;
    if (sat) begin
      lo = sgn ? -(longint'(1) << (W - 1)) : 0;
      hi = sgn ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
      if (v > hi) v = hi;
      if (v < lo) v = lo;
    end
    return int'(v & ((longint'(1) << W) - 1));
  endfunction

  task automatic update_model(input mat_t a, input mat_t b, input bit acc, input bit sgn);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint p, s0, s1;
        p = 0;
        for (int k = 0; k < N; k++) p += sval(a[i][k], sgn) * sval(b[k][j], sgn);
        s0 = acc ? sval(m_wrap[i][j], sgn) : 0;
        s1 = acc ? sval(m_sat[i][j], sgn) : 0;
        m_wrap[i][j] = fmt_ref(s0 + p, sgn, 1'b0);
        m_sat[i][j]  = fmt_ref(s1 + p, sgn, 1'b1);
      end
    end
  endtask

  task automatic rand_mat(output mat_t m);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = int'($urandom_range(0, (1 << W) - 1));
  endtask

  task automatic fill_mat(output mat_t m, input int val);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = val;
  endtask

  // Called #1 after a clock edge; returns #1 after the edge on which done should rise.
  task automatic do_run(input string name, input mat_t a, input mat_t b, input bit acc,
                        input bit sgn, input bit hold_start, input bit pulse_ignored);
    bit   busy_ok;
    mat_t junk;
    bus0.tensor_core_input1 = pack(a);
    bus0.tensor_core_input2 = pack(b);
    bus0.accumulate_mode    = acc;
    bus0.signed_mode        = sgn;
    bus0.start              = 1'b1;
    update_model(a, b, acc, sgn);
    @(posedge clk);
    #1;
    check({name, "/busy_after_accept"}, {bus0.busy, bus1.busy}, 2'b11);
    check({name, "/done_cleared"}, {bus0.is_done_with_calculation, bus1.is_done_with_calculation}, 2'b00);
    if (!hold_start) bus0.start = 1'b0;
    busy_ok = 1'b1;
    for (int e = 1; e <= RUN_CYC; e++) begin
      @(posedge clk);
      #1;
      if (e < RUN_CYC &&
          !(bus0.busy && bus1.busy && !bus0.is_done_with_calculation && !bus1.is_done_with_calculation))
        busy_ok = 1'b0;
      if (pulse_ignored && (e == 5 || e == 30)) begin
        bus0.start = 1'b1;
        rand_mat(junk);
        bus0.tensor_core_input1 = pack(junk);
        rand_mat(junk);
        bus0.tensor_core_input2 = pack(junk);
        bus0.accumulate_mode    = ~acc;
        bus0.signed_mode        = ~sgn;
      end else if (pulse_ignored && (e == 6 || e == 31)) begin
        bus0.start = 1'b0;
      end
    end
    check({name, "/busy_window"}, busy_ok, 1'b1);
    check({name, "/done_edge"}, {bus0.is_done_with_calculation, bus1.is_done_with_calculation}, 2'b11);
    check({name, "/busy_drop"}, {bus0.busy, bus1.busy}, 2'b00);
    check({name, "/out_wrap"}, bus0.tensor_core_output, pack(m_wrap));
    check({name, "/out_sat"}, bus1.tensor_core_output, pack(m_sat));
  endtask

  initial begin
    mat_t ident, seq, m16, mneg1, m3, ones, ra, rb;
    int   gap;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ident[i][j] = (i == j) ? 1 : 0;
        seq[i][j]   = i * N + j + 1;
      end
    fill_mat(m16, 16);
    fill_mat(mneg1, (1 << W) - 1);
    fill_mat(m3, 3);
    fill_mat(ones, 1);
    fill_mat(m_wrap, 0);
    fill_mat(m_sat, 0);

    rst                     = 1'b1;
    bus0.start              = 1'b0;
    bus0.accumulate_mode    = 1'b0;
    bus0.signed_mode        = 1'b0;
    bus0.tensor_core_input1 = '0;
    bus0.tensor_core_input2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/out_wrap", bus0.tensor_core_output, '0);
    check("reset/out_sat", bus1.tensor_core_output, '0);
    check("reset/busy_done", {bus0.busy, bus0.is_done_with_calculation, bus1.busy,
                              bus1.is_done_with_calculation}, 4'b0000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_run("identity", ident, seq, 1'b0, 1'b0, 1'b0, 1'b0);
    check("identity/equals_b", bus0.tensor_core_output, pack(seq));
    do_run("all16_unsigned", m16, m16, 1'b0, 1'b0, 1'b0, 1'b0);
    do_run("signed_neg", mneg1, m3, 1'b0, 1'b1, 1'b0, 1'b0);
    // Start held high across the first run: the accumulate run must follow with no gap.
    do_run("ones", ones, ones, 1'b0, 1'b0, 1'b1, 1'b0);
    do_run("ones_accum", ones, ones, 1'b1, 1'b0, 1'b0, 1'b0);
    do_run("start_ignored", ident, seq, 1'b0, 1'b0, 1'b0, 1'b1);

    rand_mat(ra);
    rand_mat(rb);
    bus0.tensor_core_input1 = pack(ra);
    bus0.tensor_core_input2 = pack(rb);
    bus0.accumulate_mode    = 1'b0;
    bus0.signed_mode        = 1'b0;
    bus0.start              = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst        = 1'b1;
    bus0.start = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus0.start = 1'b0;
    fill_mat(m_wrap, 0);
    fill_mat(m_sat, 0);
    check("midreset/out_wrap", bus0.tensor_core_output, '0);
    check("midreset/out_sat", bus1.tensor_core_output, '0);
    check("midreset/busy_done", {bus0.busy, bus0.is_done_with_calculation, bus1.busy,
                                 bus1.is_done_with_calculation}, 4'b0000);
    do_run("after_reset", ra, rb, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rand_mat(ra);
      rand_mat(rb);
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      if (gap > 0) check($sformatf("rand%0d/done_hold", r), bus0.is_done_with_calculation, 1'b1);
      do_run($sformatf("rand%0d", r), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
